dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024; the SHALL set the number of 32-bit words of storage and be a power of two.
REQ-002 Parameter WAIT_STATES, default 1, range 0..7; the SHALL set the number of extra cycles inserted per access.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous and active-high.
REQ-005 req_i  input  1  access request, sampled only in IDLE.
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 add_i  input  32  byte address; bits [1:0] give the lane offset.
REQ-008 ble_i  input  4  byte-lane enables; legal patterns are 0001, 0010, 0100, 1000, 0011, 1100 and 1111.
REQ-009 di_i  input  32  write data, already lane-aligned by the initiator.
REQ-010 do_o  output  32  registered read data, full word with all lanes.
REQ-011 ack_o  output  1  one-cycle pulse marking access completion.
REQ-012 stall_o  output  1  high while an accepted access is incomplete; intended to drive the pipeline stall_exec input.
REQ-013 err_o  output  1  error flag, valid together with ack_o.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with req_i=1, the block SHALL latch we_i, add_i, ble_i and di_i, then go to WAIT if WAIT_STATES>0, otherwise to RESP.
REQ-016 In IDLE with req_i=0, the block SHALL stay in IDLE with stall_o=0 and ack_o=0.
REQ-017 WAIT SHALL use a 3-bit down-counter loaded with WAIT_STATES-1; when the counter reaches 0 the FSM SHALL go to RESP.
REQ-018 stall_o SHALL be 1 in WAIT and 0 in IDLE and RESP, so total latency is WAIT_STATES+1 cycles from acceptance to ack_o.
REQ-019 On the edge that enters RESP, a read SHALL load do_o with the addressed word; a write SHALL update only the bytes whose latched ble bit is 1 and leave do_o unchanged.
REQ-020 In RESP, ack_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-021 Any req_i seen during WAIT or RESP SHALL be ignored; the initiator holds req_i until ack_o.
REQ-022 The word index SHALL be add_i[log2(DEPTH_WORDS)+1:2].
REQ-023 A write followed immediately by a read of the same word SHALL return the newly written bytes.
REQ-024 ble_i=0000 SHALL complete normally with no storage change.

Reset
REQ-025 While rst_i=1 the block SHALL hold state IDLE, counter 0, do_o=0, ack_o=0, stall_o=0 and err_o=0.
REQ-026 Reset asserted during WAIT or RESP SHALL abort the access; a pending write SHALL NOT modify storage, and ack_o SHALL NOT be issued.
REQ-027 Storage contents SHALL NOT be reset.

Configuration
REQ-028 With macro DMEM_RESPONDER_ERR_EN defined, err_o SHALL be 1 at ack_o when add_i[31:log2(DEPTH_WORDS)+2] is nonzero or the latched ble_i is illegal or misaligned to add_i[1:0].
REQ-029 Under the same macro, a flagged write SHALL NOT modify storage and a flagged read SHALL return do_o=0.
REQ-030 Without DMEM_RESPONDER_ERR_EN, err_o SHALL be constant 0 and upper address bits SHALL be ignored, so addresses wrap modulo the storage size.

Structure
REQ-031 The shared package RV32i_pkg SHALL hold typedef dmem_state_t (IDLE, WAIT, RESP) and the legal-ble constants.
REQ-032 Storage SHALL be a sub-module dmem_ram: a byte-lane-writable synchronous RAM with one read/write port.
REQ-033 The FSM, counter and error check SHALL live in dmem_responder.

Verification
REQ-034 Word write: WAIT_STATES=1, write 0xDEADBEEF to 0x10 with ble 1111, then read 0x10 -> stall_o high 1 cycle, ack_o on cycle 2, do_o=0xDEADBEEF.
REQ-035 Byte merge: word 0x11223344 at 0x20, write di=0x00AA0000 with ble 0100, then read 0x20 -> do_o=0x11AA3344.
REQ-036 Zero wait: WAIT_STATES=0, back-to-back reads of 0x0 and 0x4 -> stall_o never high, ack_o 1 cycle after each acceptance.
REQ-037 Reset abort: WAIT_STATES=3, write 0x55 to 0x8, assert rst_i during the second WAIT cycle -> no ack_o, a later read of 0x8 returns the old value, outputs 0 during reset.
REQ-038 Error path (macro on): DEPTH_WORDS=1024, read 0x00001000 -> err_o=1 with ack_o and do_o=0; ble 0011 at 0x22 -> err_o=1.
REQ-039 Wrap (macro off): write 0x77 to 0x00001004, read 0x4 -> do_o=0x77, err_o=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared data-memory types: responder FSM states and legal byte-lane patterns.
// Also provides the lane/offset alignment check used when DMEM_RESPONDER_ERR_EN is set.
package RV32i_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic [3:0] BLE_NONE = 4'b0000;
  localparam logic [3:0] BLE_B0   = 4'b0001;
  localparam logic [3:0] BLE_B1   = 4'b0010;
  localparam logic [3:0] BLE_B2   = 4'b0100;
  localparam logic [3:0] BLE_B3   = 4'b1000;
  localparam logic [3:0] BLE_HLO  = 4'b0011;
  localparam logic [3:0] BLE_HHI  = 4'b1100;
  localparam logic [3:0] BLE_WORD = 4'b1111;

  // An empty lane mask is a legal no-op access at any offset.
  function automatic logic ble_bad(
    input logic [3:0] ble,
    input logic [1:0] off
  );
    logic r;
    r = 1'b1;
    unique case (1'b1)
      (ble == BLE_NONE): r = 1'b0;
      (ble == BLE_B0):   r = (off != 2'd0);
      (ble == BLE_B1):   r = (off != 2'd1);
      (ble == BLE_B2):   r = (off != 2'd2);
      (ble == BLE_B3):   r = (off != 2'd3);
      (ble == BLE_HLO):  r = (off != 2'd0);
      (ble == BLE_HHI):  r = (off != 2'd2);
      (ble == BLE_WORD): r = (off != 2'd0);
      default:           r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-lane writable synchronous RAM with a single read/write port.
// Storage has no reset; only the read-data register is cleared.
module dmem_ram
  import RV32i_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic          clr_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   di_i,
  output logic [31:0]   do_o
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_do;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) r_mem[idx_i][8*b +: 8] <= di_i[8*b +: 8];
      end
    end
  end

  // A flagged read returns zero instead of the stored word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_do <= '0;
    end else if (en_i && !we_i) begin
      r_do <= clr_i ? '0 : r_mem[idx_i];
    end
  end

  assign do_o = r_do;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/WAIT/RESP FSM with programmable wait states.
// Define DMEM_RESPONDER_ERR_EN to flag out-of-range or misaligned accesses on err_o.
module dmem_responder
  import RV32i_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] add_i,
  input  logic [3:0]  ble_i,
  input  logic [31:0] di_i,
  output logic [31:0] do_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LP_LOAD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  dmem_state_t   r_state, w_next;
  logic [2:0]    r_cnt, w_cnt;
  logic          r_we, r_err;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_ble;
  logic [31:0]   r_di;

  logic          w_acc, w_fire, w_err_now;
  logic          w_we, w_err;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_ble;
  logic [31:0]   w_di;

  assign w_acc = (r_state == IDLE) && req_i;

`ifdef DMEM_RESPONDER_ERR_EN
  assign w_err_now = (add_i[31:AW+2] != '0) ||
                     ble_bad(ble_i, add_i[1:0]);
  assign err_o     = ack_o && r_err;
`else
  logic w_unused;
  assign w_unused  = &{1'b0, add_i[31:AW+2]};
  assign w_err_now = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Zero-wait accesses hit the RAM on the accept edge, so bypass the latches.
  always_comb begin
    w_we  = r_we;
    w_idx = r_idx;
    w_ble = r_ble;
    w_di  = r_di;
    w_err = r_err;
    if (r_state == IDLE) begin
      w_we  = we_i;
      w_idx = add_i[AW+1:2];
      w_ble = ble_i;
      w_di  = di_i;
      w_err = w_err_now;
    end
  end

  assign w_fire = !rst_i && (
    (w_acc && (WAIT_STATES == 0)) ||
    ((r_state == WAIT) && (r_cnt == 3'd0)));

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req_i) begin
          if (WAIT_STATES > 0) begin
            w_next = WAIT;
            w_cnt  = LP_LOAD;
          end else begin
            w_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) w_next = RESP;
        else               w_cnt  = r_cnt - 3'd1;
      end
      RESP: begin
        w_next = IDLE;
        w_cnt  = 3'd0;
      end
      default: begin
        w_next = IDLE;
        w_cnt  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_ble   <= '0;
      r_di    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_acc) begin
        r_we  <= we_i;
        r_idx <= add_i[AW+1:2];
        r_ble <= ble_i;
        r_di  <= di_i;
        r_err <= w_err_now;
      end
    end
  end

  assign stall_o = (r_state == WAIT);
  assign ack_o   = (r_state == RESP);

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (w_fire),
    .we_i  (w_we),
    .be_i  (w_ble & {4{~w_err}}),
    .clr_i (w_err),
    .idx_i (w_idx),
    .di_i  (w_di),
    .do_o  (do_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 3 wait states.
// Table-driven accesses plus hand sequences for zero-wait and reset abort.
module tb_dmem_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] add   [NI];
  logic [3:0]  ble   [NI];
  logic [31:0] di    [NI];
  logic [31:0] dout  [NI];
  logic        ack   [NI];
  logic        stall [NI];
  logic        err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst[g]),
      .req_i  (req[g]),
      .we_i   (we[g]),
      .add_i  (add[g]),
      .ble_i  (ble[g]),
      .di_i   (di[g]),
      .do_o   (dout[g]),
      .ack_o  (ack[g]),
      .stall_o(stall[g]),
      .err_o  (err[g])
    );
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp_do;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic vec(input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     input logic [31:0] e, input logic ee);
    vec_t v;
    v.w = w; v.a = a; v.b = b; v.d = d;
    v.exp_do = e; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  // Returns lat = edges from acceptance to ack (-1 on timeout).
  task automatic access(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rdo, output logic rerr,
                        output int lat, output int nst);
    bit got;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; add[k] = a; ble[k] = b; di[k] = d;
    lat = 0; nst = 0; rdo = '0; rerr = 1'b0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (stall[k]) nst++;
      if (ack[k]) begin
        got  = 1'b1;
        rdo  = dout[k];
        rerr = err[k];
      end
    end
    req[k] = 1'b0;
    if (!got) lat = -1;
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack[k]), 32'd0);
  endtask

  logic [31:0] r_do;
  logic        r_err;
  int          lat, nst;
  int          ack_seen;

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
      add[k] = '0; ble[k] = '0; di[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_do", dout[k], 32'd0);
      check("rst_ack", 32'(ack[k]), 32'd0);
      check("rst_stall", 32'(stall[k]), 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    vec(1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        0);
    vec(0, 32'h10, 4'hF, 32'h0,        32'hDEADBEEF, 0);
    vec(1, 32'h20, 4'hF, 32'h11223344, 32'hDEADBEEF, 0);
    vec(1, 32'h22, 4'h4, 32'h00AA0000, 32'hDEADBEEF, 0);
    vec(0, 32'h20, 4'hF, 32'h0,        32'h11AA3344, 0);
    vec(1, 32'h24, 4'hF, 32'h00000000, 32'h11AA3344, 0);
    vec(1, 32'h24, 4'h1, 32'h000000CC, 32'h11AA3344, 0);
    vec(1, 32'h27, 4'h8, 32'h99000000, 32'h11AA3344, 0);
    vec(1, 32'h25, 4'h2, 32'h0000BB00, 32'h11AA3344, 0);
    vec(0, 32'h24, 4'hF, 32'h0,        32'h9900BBCC, 0);
    vec(1, 32'h28, 4'hF, 32'hA5A5A5A5, 32'h9900BBCC, 0);
    vec(1, 32'h2A, 4'hC, 32'h12340000, 32'h9900BBCC, 0);
    vec(0, 32'h28, 4'hF, 32'h0,        32'h1234A5A5, 0);
    vec(1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h1234A5A5, 0);
    vec(0, 32'h10, 4'hF, 32'h0,        32'hDEADBEEF, 0);
`ifdef DMEM_RESPONDER_ERR_EN
    vec(0, 32'h1000, 4'hF, 32'h0,      32'h0,        1);
    vec(0, 32'h22,   4'h3, 32'h0,      32'h0,        1);
    vec(1, 32'h1010, 4'hF, 32'h0,      32'h0,        1);
    vec(0, 32'h10,   4'hF, 32'h0,      32'hDEADBEEF, 0);
    vec(1, 32'h11,   4'hF, 32'h0,      32'hDEADBEEF, 1);
    vec(0, 32'h10,   4'hF, 32'h0,      32'hDEADBEEF, 0);
`else
    vec(1, 32'h1004, 4'hF, 32'h77,     32'hDEADBEEF, 0);
    vec(0, 32'h4,    4'hF, 32'h0,      32'h00000077, 0);
`endif

    foreach (tbl[i]) begin
      access(0, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d,
             r_do, r_err, lat, nst);
      check($sformatf("v%0d_do", i), r_do, tbl[i].exp_do);
      check($sformatf("v%0d_err", i), 32'(r_err), 32'(tbl[i].exp_err));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_stall", i), 32'(nst), 32'd1);
    end

    access(1, 1, 32'h0, 4'hF, 32'hCAFEF00D, r_do, r_err, lat, nst);
    check("ws0_w0_lat", 32'(lat), 32'd1);
    access(1, 1, 32'h4, 4'hF, 32'h0BADF00D, r_do, r_err, lat, nst);
    check("ws0_w1_stall", 32'(nst), 32'd0);
    access(1, 0, 32'h0, 4'hF, 32'h0, r_do, r_err, lat, nst);
    check("ws0_r0_do", r_do, 32'hCAFEF00D);
    check("ws0_r0_lat", 32'(lat), 32'd1);
    check("ws0_r0_stall", 32'(nst), 32'd0);
    access(1, 0, 32'h4, 4'hF, 32'h0, r_do, r_err, lat, nst);
    check("ws0_r1_do", r_do, 32'h0BADF00D);
    check("ws0_r1_lat", 32'(lat), 32'd1);
    check("ws0_r1_err", 32'(r_err), 32'd0);

    access(2, 1, 32'h8, 4'hF, 32'h12345678, r_do, r_err, lat, nst);
    check("ws3_w_lat", 32'(lat), 32'd4);
    check("ws3_w_stall", 32'(nst), 32'd3);
    access(2, 0, 32'h8, 4'hF, 32'h0, r_do, r_err, lat, nst);
    check("ws3_r_do", r_do, 32'h12345678);

    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; add[2] = 32'h8;
    ble[2] = 4'hF; di[2] = 32'h55;
    @(posedge clk); #1;
    check("abort_wait1", 32'(stall[2]), 32'd1);
    @(posedge clk); #1;
    check("abort_wait2", 32'(stall[2]), 32'd1);
    rst[2] = 1'b1;
    #1;
    check("abort_do", dout[2], 32'd0);
    check("abort_stall", 32'(stall[2]), 32'd0);
    check("abort_ack", 32'(ack[2]), 32'd0);
    check("abort_err", 32'(err[2]), 32'd0);
    ack_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack[2]) ack_seen++;
    end
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack[2]) ack_seen++;
    end
    check("abort_no_ack", 32'(ack_seen), 32'd0);
    access(2, 0, 32'h8, 4'hF, 32'h0, r_do, r_err, lat, nst);
    check("abort_old_data", r_do, 32'h12345678);
    check("abort_read_lat", 32'(lat), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
